// File: rtl/tff_pkg.sv
// Shared constants for the T-flip-flop counter family.
package tff_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int unsigned TFF_MAX_WIDTH = 16;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop bit with async reset to a tied value and a
// synchronous load that takes priority over toggle.
module tff_cell
  import tff_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic RSTVAL,
  input  logic T,
  input  logic LD,
  input  logic LDVAL,
  output logic Q,
  output logic nQ
);

  // nQ is its own register so it never lags Q.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q  <= RSTVAL;
      nQ <= ~RSTVAL;
    end else if (LD) begin
      Q  <= LDVAL;
      nQ <= ~LDVAL;
    end else if (T) begin
      Q  <= ~Q;
      nQ <= Q;
    end
  end

endmodule

// File: rtl/tff_counter.sv
// WIDTH-bit modulo counter built from tff_cell bits: hold, clamped load,
// programmable modulus. Down counting is built only with TCNT_DOWN_EN.
module tff_counter
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MODULUS     = 2 ** WIDTH,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             nHOLD,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ,
  output logic             TC,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  logic             countUp;
  logic             atTerm;
  logic [WIDTH-1:0] upCarry;
  logic [WIDTH-1:0] loadVal;
  logic [WIDTH-1:0] cellT;
  logic [WIDTH-1:0] cellLd;
  logic [WIDTH-1:0] cellLdVal;

`ifdef TCNT_DOWN_EN
  logic [WIDTH-1:0] dnCarry;

  assign countUp = (UP == DIR_UP);
  assign atTerm  = countUp ? (Q == TOP) : (Q == '0);

  always_comb begin
    dnCarry    = '0;
    dnCarry[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) dnCarry[i] = dnCarry[i-1] & ~Q[i-1];
  end
`else
  logic unusedUp;

  assign unusedUp = UP;
  assign countUp  = DIR_UP;
  assign atTerm   = (Q == TOP);
`endif

  // Up carry chain: bit i toggles when all lower bits are 1.
  always_comb begin
    upCarry    = '0;
    upCarry[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) upCarry[i] = upCarry[i-1] & Q[i-1];
  end

  assign loadVal = (32'(D) < MODULUS) ? D : TOP;

  // TC marks exactly the edge that wraps.
  assign TC = EN & nHOLD & ~LOAD & atTerm;

  always_comb begin
    cellT     = '0;
    cellLd    = '0;
    cellLdVal = '0;
    if (LOAD) begin
      cellLd    = '1;
      cellLdVal = loadVal;
    end else if (TC) begin
      // Wrap overrides the toggle chain so short moduli stay in range.
      cellLd    = '1;
      cellLdVal = countUp ? '0 : TOP;
    end else if (nHOLD && EN) begin
`ifdef TCNT_DOWN_EN
      cellT = countUp ? upCarry : dnCarry;
`else
      cellT = upCarry;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) WRAP <= 1'b0;
    else     WRAP <= TC;
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : gCell
    tff_cell uCell (
      .CLK   (CLK),
      .RST   (RST),
      .RSTVAL(RST_VAL[i]),
      .T     (cellT[i]),
      .LD    (cellLd[i]),
      .LDVAL (cellLdVal[i]),
      .Q     (Q[i]),
      .nQ    (nQ[i])
    );
  end

endmodule

// File: tb/tb_tff_counter.sv
// Scoreboard bench for tff_counter: dut A (mod 16, reset 5), dut B (mod 10).
module tb_tff_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       aRst = 1'b1, aEn = 1'b0, aHold = 1'b1, aLoad = 1'b0, aUp = 1'b1;
  logic [3:0] aD = '0;
  logic [3:0] aQ, aNq;
  logic       aTc, aWrap;

  logic       bRst = 1'b1, bEn = 1'b0, bHold = 1'b1, bLoad = 1'b0, bUp = 1'b1;
  logic [3:0] bD = '0;
  logic [3:0] bQ, bNq;
  logic       bTc, bWrap;

  tff_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(5)) dutA (
    .CLK(clk), .RST(aRst), .EN(aEn), .nHOLD(aHold), .LOAD(aLoad), .D(aD), .UP(aUp),
    .Q(aQ), .nQ(aNq), .TC(aTc), .WRAP(aWrap)
  );

  tff_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dutB (
    .CLK(clk), .RST(bRst), .EN(bEn), .nHOLD(bHold), .LOAD(bLoad), .D(bD), .UP(bUp),
    .Q(bQ), .nQ(bNq), .TC(bTc), .WRAP(bWrap)
  );

  typedef struct {
    bit         sel;
    string      name;
    logic [3:0] q;
    logic       tc;
    logic       wrap;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs on the falling edge, then post what the outputs must show.
  task automatic drive(input bit sel, input logic rst, input logic en, input logic nhold,
                       input logic load, input logic [3:0] d, input logic up,
                       input string name, input logic [3:0] q, input logic tc,
                       input logic wrap);
    exp_t e;
    @(negedge clk);
    if (!sel) begin
      aRst = rst; aEn = en; aHold = nhold; aLoad = load; aD = d; aUp = up;
    end else begin
      bRst = rst; bEn = en; bHold = nhold; bLoad = load; bD = d; bUp = up;
    end
    #1;
    e.sel = sel; e.name = name; e.q = q; e.tc = tc; e.wrap = wrap;
    sbq.push_back(e);
  endtask

  // Monitor: pops every posted expectation and compares it against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (!e.sel) begin
          check({e.name, ".Q"}, aQ, e.q);
          check({e.name, ".nQ"}, aNq, ~e.q);
          check({e.name, ".TC"}, 4'(aTc), 4'(e.tc));
          check({e.name, ".WRAP"}, 4'(aWrap), 4'(e.wrap));
        end else begin
          check({e.name, ".Q"}, bQ, e.q);
          check({e.name, ".nQ"}, bNq, ~e.q);
          check({e.name, ".TC"}, 4'(bTc), 4'(e.tc));
          check({e.name, ".WRAP"}, 4'(bWrap), 4'(e.wrap));
        end
      end
    end
  end

`ifdef TCNT_DOWN_EN
  localparam logic [3:0] DN_Q [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
  localparam logic       DN_TC[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic       DN_WR[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
  localparam logic [3:0] DN_Q [5] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
  localparam logic       DN_TC[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic       DN_WR[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

  initial begin
    int guard;
    // dut A: reset, full range, async reset mid-count, in-flight wrap cleared
    drive(0, 1, 0, 1, 0, 4'd0, 1, "aReset", 4'd5, 0, 0);
    drive(0, 0, 1, 1, 1, 4'd0, 1, "aLoad0", 4'd5, 0, 0);
    for (int k = 0; k < 16; k++)
      drive(0, 0, 1, 1, 0, 4'd0, 1, "aCount", 4'(k), (k == 15), 0);
    drive(0, 0, 1, 1, 0, 4'd0, 1, "aWrapPulse", 4'd0, 0, 1);
    for (int k = 1; k < 9; k++)
      drive(0, 0, 1, 1, 0, 4'd0, 1, "aCount2", 4'(k), 0, 0);
    drive(0, 0, 0, 1, 0, 4'd0, 1, "aIdle9", 4'd9, 0, 0);
    drive(0, 1, 0, 1, 0, 4'd0, 1, "aAsyncRst", 4'd5, 0, 0);
    drive(0, 0, 0, 1, 1, 4'd15, 1, "aLoad15", 4'd5, 0, 0);
    drive(0, 0, 1, 1, 0, 4'd0, 1, "aTc15", 4'd15, 1, 0);
    drive(0, 1, 0, 1, 0, 4'd0, 1, "aWrapCleared", 4'd5, 0, 0);
    // simultaneous load and count at terminal value
    drive(0, 0, 0, 1, 1, 4'd15, 1, "aLoad15b", 4'd5, 0, 0);
    drive(0, 0, 1, 1, 1, 4'd4, 1, "aSimul", 4'd15, 0, 0);
    drive(0, 0, 0, 1, 0, 4'd0, 1, "aSimulRes", 4'd4, 0, 0);
    // hold beats count, load beats hold
    drive(0, 0, 0, 1, 1, 4'd7, 1, "aLoad7", 4'd4, 0, 0);
    for (int k = 0; k < 3; k++)
      drive(0, 0, 1, 0, 0, 4'd0, 1, "aHold7", 4'd7, 0, 0);
    drive(0, 0, 1, 0, 1, 4'd3, 1, "aHoldLoad", 4'd7, 0, 0);
    drive(0, 0, 0, 1, 0, 4'd0, 1, "aLoaded3", 4'd3, 0, 0);
    drive(0, 0, 0, 1, 1, 4'd15, 1, "aLoad15c", 4'd3, 0, 0);
    drive(0, 0, 1, 0, 0, 4'd0, 1, "aHoldTop", 4'd15, 0, 0);
    drive(0, 0, 1, 0, 0, 4'd0, 1, "aHoldTop2", 4'd15, 0, 0);
    drive(0, 0, 0, 1, 0, 4'd0, 1, "aHoldTop3", 4'd15, 0, 0);

    // dut B: modulus 10, clamp, wrap, down (or up-only) count, short wrap
    drive(1, 1, 0, 1, 0, 4'd0, 1, "bReset", 4'd0, 0, 0);
    drive(1, 0, 0, 1, 1, 4'd12, 1, "bClamp", 4'd0, 0, 0);
    drive(1, 0, 1, 1, 0, 4'd0, 1, "bTc9", 4'd9, 1, 0);
    drive(1, 0, 0, 1, 0, 4'd0, 1, "bWrap", 4'd0, 0, 1);
    drive(1, 0, 0, 1, 1, 4'd2, 1, "bLoad2", 4'd0, 0, 0);
    for (int k = 0; k < 5; k++)
      drive(1, 0, 1, 1, 0, 4'd0, 0, "bDown", DN_Q[k], DN_TC[k], DN_WR[k]);
    drive(1, 0, 1, 1, 0, 4'd0, 1, "bUp7", 4'd7, 0, 0);
    drive(1, 0, 1, 1, 0, 4'd0, 1, "bUp8", 4'd8, 0, 0);
    drive(1, 0, 1, 1, 0, 4'd0, 1, "bUp9", 4'd9, 1, 0);
    drive(1, 0, 0, 1, 0, 4'd0, 1, "bUpWrap", 4'd0, 0, 1);
    drive(1, 0, 0, 1, 0, 4'd0, 1, "bIdle", 4'd0, 0, 0);

    guard = 0;
    while (sbq.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #3;
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
